// File: rtl/key_decoder.sv
// PS/2 set-2 scancode decoder for the OSD and floppy menu keys.
// Tracks held keys, generates typematic repeat pulses and one-shot F11/F12 strobes.
module key_decoder #(
  parameter logic [15:0] DELAY = 16'd500,
  parameter logic [15:0] RATE  = 16'd100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  output logic [5:0] keys,
  output logic [5:0] keys_pulse,
  output logic       osd_f11,
  output logic       osd_f12
);

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXTBRK, SKIP} state_t;

  state_t     state_reg, state_next;
  logic [2:0] skip_reg, skip_next;
  logic       accept;
  logic       is_make, is_brk, is_ext;
  logic [5:0] hit, make_vec, brk_vec;
  logic       f11_hit, f12_hit, f11_held, f12_held;

  assign accept = ce & scan_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      skip_reg  <= 3'd0;
    end else begin
      state_reg <= state_next;
      skip_reg  <= skip_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    skip_next  = skip_reg;
    if (accept) begin
      case (state_reg)
        IDLE: begin
          if (scan_code == 8'hE0)      state_next = EXT;
          else if (scan_code == 8'hF0) state_next = BRK;
          else if (scan_code == 8'hE1) begin
            state_next = SKIP;
            skip_next  = 3'd7;
          end
        end
        EXT: begin
          if (scan_code == 8'hF0)                            state_next = EXTBRK;
          else if (scan_code != 8'hE0 && scan_code != 8'h12) state_next = IDLE;
        end
        BRK, EXTBRK: state_next = IDLE;
        SKIP: begin
          skip_next = skip_reg - 3'd1;
          if (skip_reg <= 3'd1) begin
            skip_next  = 3'd0;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Classify the accepted byte as a make or break event, plain or extended.
  always_comb begin
    is_make = 1'b0;
    is_brk  = 1'b0;
    is_ext  = 1'b0;
    if (accept) begin
      case (state_reg)
        IDLE: is_make = !(scan_code inside {8'hE0, 8'hF0, 8'hE1, 8'hFA, 8'hAA,
                                            8'hEE, 8'hFE, 8'h00, 8'hFF});
        EXT: begin
          is_make = !(scan_code inside {8'hF0, 8'hE0, 8'h12});
          is_ext  = 1'b1;
        end
        BRK: is_brk = 1'b1;
        EXTBRK: begin
          is_brk = 1'b1;
          is_ext = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    hit = 6'b0;
    if (scan_code == 8'h5A) hit[0] = 1'b1;
    if (is_ext) begin
      case (scan_code)
        8'h72:   hit[1] = 1'b1;
        8'h75:   hit[2] = 1'b1;
        8'h74:   hit[3] = 1'b1;
        8'h6B:   hit[4] = 1'b1;
        default: ;
      endcase
    end else if (scan_code == 8'h76) begin
      hit[5] = 1'b1;
    end
  end

  assign f11_hit  = !is_ext && scan_code == 8'h78;
  assign f12_hit  = !is_ext && scan_code == 8'h07;
  assign make_vec = is_make ? hit : 6'b0;
  assign brk_vec  = is_brk  ? hit : 6'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      osd_f11  <= 1'b0;
      osd_f12  <= 1'b0;
      f11_held <= 1'b0;
      f12_held <= 1'b0;
    end else if (!ce) begin
      osd_f11 <= 1'b0;
      osd_f12 <= 1'b0;
    end else begin
      osd_f11 <= is_make && f11_hit && !f11_held;
      osd_f12 <= is_make && f12_hit && !f12_held;
      if (is_make && f11_hit)     f11_held <= 1'b1;
      else if (is_brk && f11_hit) f11_held <= 1'b0;
      if (is_make && f12_hit)     f12_held <= 1'b1;
      else if (is_brk && f12_hit) f12_held <= 1'b0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_key
      logic        key_reg, key_next, pulse_reg;
      logic [15:0] cnt_reg;

      assign key_next       = (key_reg | make_vec[gi]) & ~brk_vec[gi];
      assign keys[gi]       = key_reg;
      assign keys_pulse[gi] = pulse_reg;

      // A release wins over a coincident expiry; a repeated make just keeps counting.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          key_reg   <= 1'b0;
          pulse_reg <= 1'b0;
          cnt_reg   <= 16'd0;
        end else if (!ce) begin
          pulse_reg <= 1'b0;
        end else begin
          key_reg <= key_next;
          if (!key_next) begin
            cnt_reg   <= 16'd0;
            pulse_reg <= 1'b0;
          end else if (!key_reg) begin
            cnt_reg   <= DELAY;
            pulse_reg <= 1'b1;
          end else if (cnt_reg <= 16'd1) begin
            cnt_reg   <= RATE;
            pulse_reg <= 1'b1;
          end else begin
            cnt_reg   <= cnt_reg - 16'd1;
            pulse_reg <= 1'b0;
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_key_decoder.sv
// Bench for key_decoder: directed scancode sequences plus random traffic, checked
// every clock against a byte-level reference model using key age for typematic timing.
module tb_key_decoder;
  localparam int D = 4;
  localparam int R = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ce = 1'b0;
  logic       scan_valid = 1'b0;
  logic [7:0] scan_code = 8'h00;
  logic [5:0] keys, keys_pulse;
  logic       osd_f11, osd_f12;

  always #5 clk = ~clk;

  key_decoder #(.DELAY(16'd4), .RATE(16'd2)) dut (
    .clk(clk), .reset(reset), .ce(ce), .scan_code(scan_code), .scan_valid(scan_valid),
    .keys(keys), .keys_pulse(keys_pulse), .osd_f11(osd_f11), .osd_f12(osd_f12)
  );

  int passed = 0;
  int total  = 0;

  bit   m_ext, m_brk;
  int   m_skip;
  bit   m_held[6];
  int   m_age[6];
  bit   m_fheld[2];
  logic [5:0] exp_keys, exp_pulse;
  logic       exp_f11, exp_f12;

  function automatic int key_index(bit ext, logic [7:0] c);
    if (c == 8'h5A) return 0;
    if (ext) begin
      if (c == 8'h72) return 1;
      if (c == 8'h75) return 2;
      if (c == 8'h74) return 3;
      if (c == 8'h6B) return 4;
    end else if (c == 8'h76) begin
      return 5;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_skip = 0;
    for (int i = 0; i < 6; i++) begin m_held[i] = 0; m_age[i] = 0; end
    m_fheld[0] = 0; m_fheld[1] = 0;
    exp_keys = '0; exp_pulse = '0; exp_f11 = 0; exp_f12 = 0;
  endtask

  task automatic model_tick(bit c, bit v, logic [7:0] b);
    bit mk, bk, ex;
    int k, fk;
    exp_pulse = '0; exp_f11 = 0; exp_f12 = 0;
    if (!c) return;
    mk = 0; bk = 0; ex = 0;
    if (v) begin
      if (m_skip > 0) m_skip--;
      else if (m_brk) begin bk = 1; ex = m_ext; m_brk = 0; m_ext = 0; end
      else if (m_ext) begin
        if (b == 8'hF0) m_brk = 1;
        else if (b != 8'hE0 && b != 8'h12) begin mk = 1; ex = 1; m_ext = 0; end
      end else begin
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else if (b == 8'hE1) m_skip = 7;
        else if (!(b inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF})) mk = 1;
      end
    end
    k = (mk || bk) ? key_index(ex, b) : -1;
    for (int i = 0; i < 6; i++) begin
      if (bk && k == i) m_held[i] = 0;
      else if (mk && k == i && !m_held[i]) begin
        m_held[i] = 1; m_age[i] = 0; exp_pulse[i] = 1;
      end else if (m_held[i]) begin
        m_age[i]++;
        if (m_age[i] >= D && (m_age[i] - D) % R == 0) exp_pulse[i] = 1;
      end
      exp_keys[i] = m_held[i];
    end
    fk = (ex || !(mk || bk)) ? -1 : (b == 8'h78) ? 0 : (b == 8'h07) ? 1 : -1;
    if (fk >= 0) begin
      if (mk && !m_fheld[fk]) begin
        if (fk == 0) exp_f11 = 1; else exp_f12 = 1;
      end
      m_fheld[fk] = mk;
    end
  endtask

  task automatic check(string tag, logic [7:0] obs, logic [7:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %h expected %h at t=%0t", tag, obs, expv, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (reset) model_reset();
    else model_tick(ce, scan_valid, scan_code);
    check("keys", {2'b0, keys}, {2'b0, exp_keys});
    check("keys_pulse", {2'b0, keys_pulse}, {2'b0, exp_pulse});
    check("osd_f11", {7'b0, osd_f11}, {7'b0, exp_f11});
    check("osd_f12", {7'b0, osd_f12}, {7'b0, exp_f12});
  endtask

  task automatic idle(int n, bit c);
    scan_valid = 0;
    for (int i = 0; i < n; i++) begin ce = c; step(); end
    ce = 1;
  endtask

  task automatic send(logic [7:0] b);
    ce = 1; scan_valid = 1; scan_code = b;
    step();
    scan_valid = 0;
    step();
  endtask

  logic [7:0] pool [16] = '{8'hE0, 8'hF0, 8'hE0, 8'hF0, 8'h5A, 8'h72, 8'h75, 8'h74,
                            8'h6B, 8'h76, 8'h78, 8'h07, 8'h12, 8'hFA, 8'hE1, 8'h33};

  initial begin
    model_reset();
    reset = 1;
    step(); step();
    reset = 0;
    idle(2, 1);

    send(8'hE0); send(8'h75); idle(3, 1);
    send(8'hE0); send(8'hF0); send(8'h75); idle(4, 1);

    send(8'h5A); idle(12, 1); idle(3, 0); idle(3, 1);
    send(8'hF0); send(8'h5A); idle(3, 1);

    send(8'h78); idle(2, 0); send(8'h78);
    send(8'hF0); send(8'h78); send(8'h78); idle(2, 1);
    send(8'hF0); send(8'h07); send(8'h07); send(8'hF0); send(8'h07); idle(2, 1);

    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    send(8'h5A); idle(3, 1); send(8'hF0); send(8'h5A);

    send(8'hFA); send(8'hE0); send(8'h12); send(8'hE0); send(8'hAA);
    send(8'h6B); idle(2, 1); send(8'hFA); idle(5, 1);
    send(8'hE0); send(8'hF0); send(8'h6B); idle(2, 1);

    send(8'h76); idle(3, 1); send(8'hE0);
    #2 reset = 1;
    #2 check("async_reset_keys", {2'b0, keys}, 8'h00);
    step();
    reset = 0;
    send(8'h72); idle(2, 1);

    for (int i = 0; i < 600; i++) begin
      ce = ($urandom_range(0, 3) != 0);
      scan_valid = ($urandom_range(0, 2) == 0);
      scan_code = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255))
                                              : pool[$urandom_range(0, 15)];
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
